// File: rtl/aes_pkg.sv
// Shared AES constants for the key schedule: S-box, Rcon, round count and FSM states.
package aes_pkg;

  // Number of AES-128 rounds; also the first round_idx of a reverse schedule.
  localparam int NR = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Forward AES S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for round r (1..NR) in the MSB byte; zero outside that range.
  function automatic logic [31:0] rcon_f(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h000000};
  endfunction

endpackage

// File: rtl/key_sub_word.sv
// Combinational RotWord followed by a 4-byte SubWord, as used by the key schedule.
module key_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  logic [31:0] rot_word;

  // Rotate bytes left by one: the MSB byte moves to the LSB position.
  assign rot_word = {word[23:0], word[31:24]};

  // One S-box lookup per byte lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_word[8*gi +: 8] = sbox_f(rot_word[8*gi +: 8]);
    end
  endgenerate

endmodule

// File: rtl/inv_key_expansion.sv
// Iterative reverse AES-128 key schedule: emits round keys 10 down to 0 from
// the final round key, one key per accepted handshake, using a single shared
// reverse-round circuit.
module inv_key_expansion
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         IN_valid,
  input  logic [127:0] last_key,
  output logic         busy,
  output logic         OUT_valid,
  input  logic         OUT_ready,
  output logic [127:0] RoundKey,
  output logic [3:0]   round_idx,
  output logic         done
);

  state_t       state_reg;
  logic [127:0] key_reg;
  logic [127:0] key_next;
  logic [3:0]   idx_reg;
  logic         valid_reg;
  logic         busy_reg;
  logic         done_reg;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w3_next;
  logic [31:0]  sub_word;
  logic         fire;

  assign w0 = key_reg[127:96];
  assign w1 = key_reg[95:64];
  assign w2 = key_reg[63:32];
  assign w3 = key_reg[31:0];

  // Undo the forward XOR chain; W3' feeds the S-boxes that recover W0'.
  assign w3_next = w3 ^ w2;

  key_sub_word u_sub_word (
    .word     (w3_next),
    .sub_word (sub_word)
  );

  // Rcon is selected by the round being stepped away from, before the decrement.
  assign key_next = {w0 ^ sub_word ^ rcon_f(idx_reg), w1 ^ w0, w2 ^ w1, w3_next};

  assign fire = valid_reg & OUT_ready;

  // Control FSM and output registers; done is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (IN_valid) begin
            key_reg   <= last_key;
            idx_reg   <= 4'(NR);
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (idx_reg != 4'd0) begin
              key_reg <= key_next;
              idx_reg <= idx_reg - 4'd1;
            end else begin
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign OUT_valid = valid_reg;
  assign RoundKey  = key_reg;
  assign round_idx = idx_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Self-checking bench for inv_key_expansion against a word-array model of the
// AES-128 key schedule with an S-box built from GF(2^8) arithmetic.
module tb_inv_key_expansion;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         IN_valid = 1'b0;
  logic [127:0] last_key = '0;
  logic         busy;
  logic         OUT_valid;
  logic         OUT_ready = 1'b0;
  logic [127:0] RoundKey;
  logic [3:0]   round_idx;
  logic         done;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_keys [11];
  logic [127:0] seen_keys [11];

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ZERO_K9  = 128'h55636363000000000000000000000000;

  inv_key_expansion dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .IN_valid  (IN_valid),
    .last_key  (last_key),
    .busy      (busy),
    .OUT_valid (OUT_valid),
    .OUT_ready (OUT_ready),
    .RoundKey  (RoundKey),
    .round_idx (round_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward schedule: w[i] = w[i-4] ^ g(w[i-1]); run backwards from w[40..43].
  task automatic model_sched(input logic [127:0] key10);
    logic [31:0] w [44];
    logic [7:0]  rc [11];
    logic [31:0] t;
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int r = 2; r <= 10; r++) rc[r] = gmul(rc[r-1], 8'h02);
    w[40] = key10[127:96];
    w[41] = key10[95:64];
    w[42] = key10[63:32];
    w[43] = key10[31:0];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t = t ^ {rc[i/4], 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One full reverse schedule: capture, drain 11 beats, check done/busy.
  task automatic run_key(input string name, input logic [127:0] key, input bit rand_rdy,
                         input bit inject, input logic [127:0] inj_key);
    int  idx = 10;
    int  beats = 0;
    bit  finished = 0;
    bit  injected = 0;
    bit  rdy;
    logic [127:0] cur_key;
    logic [3:0]   cur_idx;
    model_sched(key);
    @(negedge clk);
    IN_valid = 1'b1;
    last_key = key;
    OUT_ready = 1'b0;
    @(negedge clk);
    IN_valid = 1'b0;
    check_eq({name, " capture valid"}, 128'(OUT_valid), 128'd1);
    check_eq({name, " capture busy"}, 128'(busy), 128'd1);
    check_eq({name, " capture idx"}, 128'(round_idx), 128'd10);
    check_eq({name, " capture key"}, RoundKey, key);
    for (int cyc = 0; cyc < 400; cyc++) begin
      cur_key = RoundKey;
      cur_idx = round_idx;
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      OUT_ready = rdy;
      if (inject && !injected && cur_idx == 4'd5) begin
        IN_valid = 1'b1;
        last_key = inj_key;
        injected = 1;
      end
      @(negedge clk);
      IN_valid = 1'b0;
      if (rdy) begin
        check_eq($sformatf("%s key r%0d", name, idx), cur_key, exp_keys[idx]);
        check_eq($sformatf("%s idx r%0d", name, idx), 128'(cur_idx), 128'(idx));
        seen_keys[idx] = cur_key;
        beats++;
        if (idx == 0) begin
          finished = 1;
          break;
        end
        idx--;
      end else begin
        check_eq($sformatf("%s stall key r%0d", name, idx), RoundKey, cur_key);
        check_eq($sformatf("%s stall idx r%0d", name, idx), 128'(round_idx), 128'(cur_idx));
      end
    end
    check_eq({name, " finished"}, 128'(finished), 128'd1);
    check_eq({name, " beats"}, 128'(beats), 128'd11);
    check_eq({name, " done pulse"}, 128'(done), 128'd1);
    check_eq({name, " busy low"}, 128'(busy), 128'd0);
    check_eq({name, " valid low"}, 128'(OUT_valid), 128'd0);
    OUT_ready = 1'b1;
    @(negedge clk);
    check_eq({name, " done single"}, 128'(done), 128'd0);
    check_eq({name, " idle valid"}, 128'(OUT_valid), 128'd0);
    check_eq({name, " hold key"}, RoundKey, exp_keys[0]);
    check_eq({name, " hold idx"}, 128'(round_idx), 128'd0);
    OUT_ready = 1'b0;
    $display("run %s key=%h beats=%0d errors_so_far=%0d", name, key, beats, err_cnt);
  endtask

  initial begin
    logic [127:0] rkey;
    int guard;
    build_sbox();
    repeat (3) @(negedge clk);
    check_eq("reset valid", 128'(OUT_valid), 128'd0);
    check_eq("reset busy", 128'(busy), 128'd0);
    check_eq("reset key", RoundKey, 128'd0);
    check_eq("reset idx", 128'(round_idx), 128'd0);
    check_eq("reset done", 128'(done), 128'd0);
    reset_n = 1'b1;

    // FIPS-197 sweep with continuous ready.
    run_key("fips", FIPS_K10, 1'b0, 1'b0, '0);
    check_eq("fips round9", seen_keys[9], FIPS_K9);
    check_eq("fips round0", seen_keys[0], FIPS_K0);

    // Same key under random backpressure.
    run_key("fips_bp", FIPS_K10, 1'b1, 1'b0, '0);
    check_eq("fips_bp round0", seen_keys[0], FIPS_K0);

    // Random keys, random backpressure.
    for (int n = 0; n < 4; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_key($sformatf("rand%0d", n), rkey, 1'b1, 1'b0, '0);
    end

    // IN_valid during RUN is ignored; the new key is then taken from IDLE.
    run_key("inject", FIPS_K10, 1'b0, 1'b1, SEQ_KEY);
    check_eq("inject round0", seen_keys[0], FIPS_K0);
    run_key("after_inject", SEQ_KEY, 1'b0, 1'b0, '0);

    // Asynchronous reset in the middle of a schedule.
    @(negedge clk);
    IN_valid = 1'b1;
    last_key = FIPS_K10;
    OUT_ready = 1'b1;
    @(negedge clk);
    IN_valid = 1'b0;
    guard = 0;
    while (round_idx != 4'd4 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    check_eq("midreset reach r4", 128'(round_idx), 128'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midreset valid", 128'(OUT_valid), 128'd0);
    check_eq("midreset busy", 128'(busy), 128'd0);
    check_eq("midreset key", RoundKey, 128'd0);
    check_eq("midreset idx", 128'(round_idx), 128'd0);
    check_eq("midreset done", 128'(done), 128'd0);
    OUT_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    $display("run midreset errors_so_far=%0d", err_cnt);
    run_key("restart", FIPS_K10, 1'b1, 1'b0, '0);

    // All-zero final key.
    run_key("zero", 128'd0, 1'b0, 1'b0, '0);
    check_eq("zero round9", seen_keys[9], ZERO_K9);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
